mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access.sv | 184 ++++++++++++++++++
 tb/tb_mem_access.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared load/store encodings and mem_access FSM states.
// func3 width codes are also used by the execute stage.
package mem_access_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } ma_state_e;

  // Undefined func3 codes fall into the word case.
  function automatic logic ls_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3)
      LS_B, LS_BU: ls_misaligned = 1'b0;
      LS_H, LS_HU: ls_misaligned = off[0];
      default:     ls_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / data replication, load extract + extend.
// Ports: i_func3, i_off, i_wdata, i_rdata -> o_be, o_wdata, o_rdata (combinational).
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic        w_b;
  logic        w_h;
  logic        w_sx;
  logic [4:0]  w_sh;
  logic [31:0] w_shf;

  assign w_b  = (i_func3 == LS_B) || (i_func3 == LS_BU);
  assign w_h  = (i_func3 == LS_H) || (i_func3 == LS_HU);
  assign w_sx = ~i_func3[2];

  // Misaligned offsets are truncated to the access width.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    w_sh    = 5'd0;
    unique case (1'b1)
      w_b: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        w_sh    = {i_off, 3'b000};
      end
      w_h: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        w_sh    = {i_off[1], 4'b0000};
      end
      default: ;
    endcase
  end

  assign w_shf = i_rdata >> w_sh;

  always_comb begin
    o_rdata = w_shf;
    unique case (1'b1)
      w_b: o_rdata = {{24{w_sx & w_shf[7]}}, w_shf[7:0]};
      w_h: o_rdata = {{16{w_sx & w_shf[15]}}, w_shf[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: req/ack data bus, writeback + stall to upstream.
// Ports: clk, reset (sync, active-low), execute inputs, mem_* bus,
// wb_valid/wb_data/dest_o, stall_o, bus_err. Optional misalign trap and
// misalign_o port under MRISCV_MISALIGN_TRAP_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [2:0]  func3,
  input  logic [4:0]  dest_i,
  output logic        stall_o,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  dest_o,
`ifdef MRISCV_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  ma_state_e   r_state;
  ma_state_e   w_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [2:0]  r_f3;
  logic [4:0]  r_dest;
  logic        r_we;
  logic [CW-1:0] r_cnt;
  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_dest_o;
  logic        r_bus_err;
  logic        w_ls;
  logic        w_trap;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld;

  assign w_ls  = is_load | is_store;
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

`ifdef MRISCV_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap     = ls_misaligned(func3, result[1:0]);
  assign misalign_o = r_mis;
`else
  assign w_trap = 1'b0;
`endif

  mem_lane_align u_align (
    .i_func3 (r_f3),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_sdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_ld)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (valid_i && w_ls) w_nxt = w_trap ? ST_ERR : ST_REQ;
      ST_REQ:
        if (mem_ack)    w_nxt = ST_RESP;
        else if (w_tmo) w_nxt = ST_ERR;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (r_state)
      ST_IDLE: stall_o = valid_i & w_ls;
      ST_REQ: begin
        stall_o   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_be    = w_be;
        mem_wdata = w_wdata;
      end
      default: ;
    endcase
  end

  // Writeback regs hold one-cycle pulses; values are zero when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr     <= '0;
      r_sdata    <= '0;
      r_f3       <= '0;
      r_dest     <= '0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_dest_o   <= '0;
      r_bus_err  <= 1'b0;
`ifdef MRISCV_MISALIGN_TRAP_EN
      r_mis      <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_dest_o   <= '0;
      r_bus_err  <= 1'b0;
`ifdef MRISCV_MISALIGN_TRAP_EN
      r_mis      <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (valid_i && !w_ls) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= result;
            r_dest_o   <= dest_i;
          end else if (valid_i) begin
            r_addr  <= result;
            r_sdata <= store_data;
            r_f3    <= func3;
            r_dest  <= dest_i;
            r_we    <= ~is_load;
            if (w_trap) begin
              r_bus_err <= 1'b1;
`ifdef MRISCV_MISALIGN_TRAP_EN
              r_mis     <= 1'b1;
`endif
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_wb_valid <= 1'b1;
            if (!r_we) begin
              r_wb_data <= w_ld;
              r_dest_o  <= r_dest;
            end
          end else if (w_tmo) begin
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign dest_o   = r_dest_o;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ALU/load/store traffic vs a
// byte-arithmetic reference model, plus directed reset/timeout cases.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_i = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] result = '0;
  logic [31:0] store_data = '0;
  logic [2:0]  func3 = '0;
  logic [4:0]  dest_i = '0;
  logic        stall_o;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  dest_o;
  logic        bus_err;
  logic        misalign_o;

  int tests = 0;
  int fails = 0;
  bit late_ack = 1'b0;

`ifdef MRISCV_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
  assign misalign_o = 1'b0;
`endif

  typedef struct {
    bit          err;
    bit          mis;
    logic [31:0] data;
    logic [4:0]  dest;
  } rsp_t;

  typedef struct {
    int          dly;
    int          tmo;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  rsp_t sbq[$];
  bus_t busq[$];

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .result     (result),
    .store_data (store_data),
    .func3      (func3),
    .dest_i     (dest_i),
    .stall_o    (stall_o),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .dest_o     (dest_o),
`ifdef MRISCV_MISALIGN_TRAP_EN
    .misalign_o (misalign_o),
`endif
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes from func3.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  task automatic issue(input bit ld, input bit st,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [2:0] f3, input logic [4:0] dst,
                       input int dly, input logic [31:0] rd);
    rsp_t r;
    bus_t b;
    int n, aoff, exp_st, cnt;
    logic [31:0] mask, v;
    bit mis, s;
    n    = nbytes(f3);
    mis  = (res % n) != 0;
    aoff = (n == 4) ? 0 : (int'(res[1:0]) / n) * n;
    r.err = 0; r.mis = 0; r.data = 0; r.dest = 0;
    if (!ld && !st) begin
      r.data = res; r.dest = dst; exp_st = 0;
    end else if (TRAP && mis) begin
      r.err = 1; r.mis = 1; exp_st = 1;
    end else begin
      b.dly = dly; b.tmo = (dly < 0) ? TMO : -1;
      b.we = !ld; b.addr = res & ~32'd3; b.rdata = rd;
      b.be = 4'(((1 << n) - 1) << aoff);
      for (int i = 0; i < 4; i++)
        b.wdata[8*i +: 8] = 8'(sd >> (8 * (i % n)));
      busq.push_back(b);
      if (dly < 0) begin
        r.err = 1; exp_st = 1 + TMO;
      end else begin
        exp_st = dly + 2;
        if (ld) begin
          mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
          v = (rd >> (8 * aoff)) & mask;
          if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
          r.data = v; r.dest = dst;
        end
      end
    end
    sbq.push_back(r);
    @(negedge clk);
    valid_i = 1; is_load = ld; is_store = st; result = res;
    store_data = sd; func3 = f3; dest_i = dst;
    cnt = 0;
    forever begin
      #1 s = stall_o;
      @(posedge clk);
      if (!s) break;
      cnt++;
      if (cnt > 40) begin
        $display("FAIL stall_timeout: got %0d want %0d", cnt, exp_st);
        fails++;
        break;
      end
      @(negedge clk);
    end
    chk("stall_cycles", cnt, exp_st);
    #1 valid_i = 0; is_load = 0; is_store = 0;
  endtask

  // Monitor: every wb_valid / bus_err pulse pops one expected response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid || bus_err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", {wb_valid, bus_err}, 0);
        end else begin
          e = sbq.pop_front();
          chk("bus_err", bus_err, e.err);
          chk("wb_valid", wb_valid, !e.err);
          chk("misalign", misalign_o, e.mis);
          chk("dest_o", dest_o, e.dest);
          if (!e.err) chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Bus responder: checks each request, acks after the scheduled delay.
  initial begin
    bus_t c;
    bit act;
    int cyc;
    act = 0; cyc = 0;
    forever begin
      @(negedge clk);
      mem_ack = late_ack;
      if (mem_req) begin
        if (!act) begin
          act = 1; cyc = 0;
          if (busq.size() == 0) begin
            chk("unexpected_req", mem_req, 0);
            c.dly = -1; c.tmo = -1;
          end else begin
            c = busq.pop_front();
            chk("mem_addr", mem_addr, c.addr);
            chk("mem_be", mem_be, c.be);
            chk("mem_we", mem_we, c.we);
            if (c.we) chk("mem_wdata", mem_wdata, c.wdata);
          end
        end
        if (c.dly >= 0 && cyc == c.dly) begin
          mem_ack = 1; mem_rdata = c.rdata; act = 0;
        end
        cyc++;
      end else begin
        if (act && c.tmo >= 0) chk("tmo_cycles", cyc, c.tmo);
        act = 0;
      end
    end
  end

  initial begin
    int k, d;
    logic [2:0] f3;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", stall_o, 0);
    reset = 1;

    issue(0, 0, -32'sd100, 0, 3'b000, 5'd9, 0, 0);
    issue(1, 0, 32'h103, 0, 3'b000, 5'd5, 3, 32'h80FF_FF00);
    issue(0, 1, 32'h22, 32'h1234_ABCD, 3'b001, 5'd7, 1, 0);
    issue(1, 0, 32'h42, 0, 3'b101, 5'd4, 0, 32'hBEEF_0000);
    issue(1, 0, 32'h80, 0, 3'b010, 5'd0, 2, 32'h1357_9BDF);
    issue(1, 0, 32'h300, 0, 3'b010, 5'd6, -1, 0);
    issue(1, 0, 32'h101, 0, 3'b010, 5'd8, 0, 32'hCAFE_F00D);
    issue(0, 1, 32'h47, 32'h0000_00A5, 3'b000, 5'd2, 0, 0);

    // Reset during REQ: request drops, late ack ignored.
    busq.push_back('{-1, -1, 1'b0, 32'h200, 4'hF, 32'h0, 32'h0});
    @(negedge clk);
    valid_i = 1; is_load = 1; result = 32'h200; func3 = 3'b010;
    dest_i = 5'd3;
    @(posedge clk);
    #1 valid_i = 0; is_load = 0;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    chk("rst2_mem_req", mem_req, 0);
    chk("rst2_wb_valid", wb_valid, 0);
    chk("rst2_dest_o", dest_o, 0);
    chk("rst2_wb_data", wb_data, 0);
    reset = 1;
    late_ack = 1;
    @(negedge clk);
    late_ack = 0;
    repeat (2) @(negedge clk);
    chk("late_ack_wb", wb_valid, 0);

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 3);
      issue(k >= 3 && k < 7, k >= 7, $urandom, $urandom, f3,
            5'($urandom_range(0, 31)), d, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("bus_empty", busq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0t want <2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
